// File: rtl/lj_lut_pkg.sv
// Shared constants and types for the LJ coefficient LUT address path.
// The float32 field layout and table geometry are used by the read and write sides of the table.
package lj_lut_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned SEGMENT_NUM     = 12;
  localparam int unsigned BIN_BITS        = 8;
  localparam int unsigned ADDR_WIDTH      = 12;
  localparam int unsigned LUT_LATENCY     = 2;
  localparam int unsigned CUT_COUNT_WIDTH = 16;
  localparam logic [7:0]  MIN_EXP         = 8'd118;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;

  localparam int unsigned TABLE_DEPTH = SEGMENT_NUM << BIN_BITS;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t TOP_ADDR = addr_t'(TABLE_DEPTH - 1);

  // Side-band that travels alongside the LUT read so it lines up with q.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] r2;
    logic                  below_min;
    logic                  beyond_cut;
  } side_t;

endpackage

// File: rtl/lj_lut_addr_calc.sv
// Combinational float32 r^2 to segment/bin LUT address mapping with range flags.
module lj_lut_addr_calc
  import lj_lut_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] r2,
  output addr_t                 address,
  output logic                  below_min,
  output logic                  beyond_cut
);

  logic                sign;
  logic [7:0]          exp_f;
  logic [BIN_BITS-1:0] bin;
  logic [7:0]          seg;
  logic                unused_mant;

  assign sign        = r2[SIGN_BIT];
  assign exp_f       = r2[EXP_MSB:EXP_LSB];
  assign bin         = r2[MANT_MSB -: BIN_BITS];
  assign seg         = exp_f - MIN_EXP;
  assign unused_mant = ^r2[MANT_MSB-BIN_BITS:0];

  // Negative, Inf/NaN and over-range all clamp to the last entry; segment index is always < SEGMENT_NUM here.
  always_comb begin
    address    = '0;
    below_min  = 1'b0;
    beyond_cut = 1'b0;
    if (sign || (exp_f == 8'hFF) || (exp_f >= (MIN_EXP + 8'(SEGMENT_NUM)))) begin
      address    = TOP_ADDR;
      beyond_cut = 1'b1;
    end else if (exp_f < MIN_EXP) begin
      below_min = 1'b1;
    end else begin
      address = addr_t'({seg, bin});
    end
  end

endmodule

// File: rtl/lj_lut_addr_gen.sv
// Drives the coefficient LUT read port from a float32 r^2 stream and delays r^2 plus range
// flags so they leave aligned with the LUT q; valid/ready on both sides, stalls freeze everything.
module lj_lut_addr_gen
  import lj_lut_pkg::*;
(
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       ivalid,
  output logic                       iready,
  input  logic [DATA_WIDTH-1:0]      r2,
  input  logic                       oready,
  output logic                       ovalid,
  output addr_t                      address,
  output logic                       rden,
  output logic [DATA_WIDTH-1:0]      r2_out,
  output logic                       below_min,
  output logic                       beyond_cut,
  output logic [CUT_COUNT_WIDTH-1:0] cut_count
);

  localparam int unsigned LAST = LUT_LATENCY;

  addr_t            calc_addr;
  logic             calc_below;
  logic             calc_beyond;
  logic             advance;
  logic             accept;
  logic [LAST:0]    vld;
  side_t            stage [LAST+1];

  lj_lut_addr_calc u_calc (
    .r2         (r2),
    .address    (calc_addr),
    .below_min  (calc_below),
    .beyond_cut (calc_beyond)
  );

  // Whole pipe moves as one; it can only move when the tail is empty or being drained.
  assign advance = !vld[LAST] || oready;
  assign iready  = advance;
  assign accept  = ivalid && advance;

  // S0 owns the LUT address register input; S1..S2 mirror the LUT's internal registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld     <= '0;
      address <= '0;
      rden    <= 1'b0;
      for (int unsigned i = 0; i <= LAST; i++) begin
        stage[i] <= '0;
      end
    end else begin
      rden <= accept;
      if (advance) begin
        vld <= {vld[LAST-1:0], ivalid};
        if (accept) begin
          address  <= calc_addr;
          stage[0] <= '{r2: r2, below_min: calc_below, beyond_cut: calc_beyond};
        end
        for (int unsigned i = 1; i <= LAST; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end
  end

  // Counts delivered (not merely presented) cut-off results, sticking at all-ones.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cut_count <= '0;
    end else if (vld[LAST] && oready && stage[LAST].beyond_cut && (cut_count != '1)) begin
      cut_count <= cut_count + CUT_COUNT_WIDTH'(1);
    end
  end

  assign ovalid     = vld[LAST];
  assign r2_out     = stage[LAST].r2;
  assign below_min  = stage[LAST].below_min;
  assign beyond_cut = stage[LAST].beyond_cut;

endmodule

// File: tb/tb_lj_lut_addr_gen.sv
// Directed bench for lj_lut_addr_gen: vector table, stalled stream, mid-stream reset, saturation.
module tb_lj_lut_addr_gen;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ivalid;
  logic        iready;
  logic [31:0] r2;
  logic        oready;
  logic        ovalid;
  logic [11:0] address;
  logic        rden;
  logic [31:0] r2_out;
  logic        below_min;
  logic        beyond_cut;
  logic [15:0] cut_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r2;
    logic [11:0] addr;
    logic        bm;
    logic        bc;
  } vec_t;

  vec_t vecs [13];
  vec_t exp_q [$];
  logic [31:0] src [16];

  lj_lut_addr_gen dut (
    .clock      (clock),
    .resetn     (resetn),
    .ivalid     (ivalid),
    .iready     (iready),
    .r2         (r2),
    .oready     (oready),
    .ovalid     (ovalid),
    .address    (address),
    .rden       (rden),
    .r2_out     (r2_out),
    .below_min  (below_min),
    .beyond_cut (beyond_cut),
    .cut_count  (cut_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference mapping for the streamed values.
  function automatic vec_t ref_map(input logic [31:0] v);
    vec_t r;
    int e;
    int b;
    e = int'(v[30:23]);
    b = int'(v[22:15]);
    r.r2 = v;
    r.addr = 12'd0;
    r.bm = 1'b0;
    r.bc = 1'b0;
    if (v[31] || e >= 130) begin
      r.addr = 12'd3071;
      r.bc = 1'b1;
    end else if (e < 118) begin
      r.bm = 1'b1;
    end else begin
      r.addr = 12'((e - 118) * 256 + b);
    end
    return r;
  endfunction

  initial begin
    int lat;
    int exp_cuts;
    int sent;
    int got;
    int stale;
    logic prev_acc;
    logic [11:0] prev_addr;
    logic [11:0] hold_addr;
    vec_t e;

    vecs[0]  = '{32'h3F800000, 12'd2304, 1'b0, 1'b0};
    vecs[1]  = '{32'h3BC00000, 12'd384,  1'b0, 1'b0};
    vecs[2]  = '{32'h3B000000, 12'd0,    1'b0, 1'b0};
    vecs[3]  = '{32'h3A800000, 12'd0,    1'b1, 1'b0};
    vecs[4]  = '{32'h00000000, 12'd0,    1'b1, 1'b0};
    vecs[5]  = '{32'h42000000, 12'd3071, 1'b0, 1'b1};
    vecs[6]  = '{32'hBF800000, 12'd3071, 1'b0, 1'b1};
    vecs[7]  = '{32'h7FC00000, 12'd3071, 1'b0, 1'b1};
    vecs[8]  = '{32'h3F9A0000, 12'd2356, 1'b0, 1'b0};
    vecs[9]  = '{32'h40FFFFFF, 12'd3071, 1'b0, 1'b0};
    vecs[10] = '{32'h41000000, 12'd3071, 1'b0, 1'b1};
    vecs[11] = '{32'h00000001, 12'd0,    1'b1, 1'b0};
    vecs[12] = '{32'h80000000, 12'd3071, 1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      src[i] = {1'b0, 8'(115 + i), 23'(i * 32'h0004F3A1)};
    end
    src[10][31] = 1'b1;

    resetn = 1'b0;
    ivalid = 1'b0;
    oready = 1'b1;
    r2     = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_r2_out", r2_out, 32'd0);
    chk("rst_flags", 32'({below_min, beyond_cut}), 32'd0);
    chk("rst_cut_count", 32'(cut_count), 32'd0);
    chk("rst_iready", 32'(iready), 32'd1);

    // Single items through an idle pipe.
    exp_cuts = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      chk("idle_iready", 32'(iready), 32'd1);
      r2 = vecs[i].r2;
      ivalid = 1'b1;
      @(negedge clock);
      ivalid = 1'b0;
      r2 = '0;
      chk("vec_address", 32'(address), 32'(vecs[i].addr));
      chk("vec_rden", 32'(rden), 32'd1);
      lat = 1;
      while (!ovalid && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_r2_out", r2_out, vecs[i].r2);
      chk("vec_below_min", 32'(below_min), 32'(vecs[i].bm));
      chk("vec_beyond_cut", 32'(beyond_cut), 32'(vecs[i].bc));
      if (vecs[i].bc) exp_cuts++;
      @(negedge clock);
      chk("vec_ovalid_drop", 32'(ovalid), 32'd0);
      chk("vec_cut_count", 32'(cut_count), 32'(exp_cuts));
      if (i == 7) chk("cut_count_three", 32'(cut_count), 32'd3);
    end

    // Back-to-back stream with a 4-cycle output stall.
    sent = 0;
    got = 0;
    prev_acc = 1'b0;
    prev_addr = '0;
    hold_addr = '0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clock);
      if (prev_acc) chk("stream_address", 32'(address), 32'(prev_addr));
      oready = !(c >= 6 && c <= 9);
      if (sent < 16) begin
        ivalid = 1'b1;
        r2 = src[sent];
      end else begin
        ivalid = 1'b0;
      end
      #1;
      if (c == 6) begin
        chk("stall_ovalid", 32'(ovalid), 32'd1);
        chk("stall_iready", 32'(iready), 32'd0);
        hold_addr = address;
      end
      if (c > 6 && c <= 9) begin
        chk("stall_iready_hold", 32'(iready), 32'd0);
        chk("stall_rden", 32'(rden), 32'd0);
        chk("stall_address", 32'(address), 32'(hold_addr));
      end
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_r2_out", r2_out, e.r2);
          chk("stream_flags", 32'({below_min, beyond_cut}), 32'({e.bm, e.bc}));
          if (e.bc) exp_cuts++;
        end
        got++;
      end
      prev_acc = ivalid && iready;
      if (prev_acc) begin
        e = ref_map(src[sent]);
        exp_q.push_back(e);
        prev_addr = e.addr;
        sent++;
      end
    end
    ivalid = 1'b0;
    oready = 1'b1;
    chk("stream_count", 32'(got), 32'd16);
    stale = 0;
    repeat (6) begin
      @(negedge clock);
      if (ovalid) stale++;
    end
    chk("stream_no_dup", 32'(stale), 32'd0);
    chk("stream_cut_count", 32'(cut_count), 32'(exp_cuts));

    // Reset with three items in flight.
    @(negedge clock);
    ivalid = 1'b1;
    r2 = 32'h42000000;
    @(negedge clock);
    r2 = 32'hBF800000;
    @(negedge clock);
    r2 = 32'h7FC00000;
    @(negedge clock);
    ivalid = 1'b0;
    chk("inflight_ovalid", 32'(ovalid), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("midrst_ovalid", 32'(ovalid), 32'd0);
    chk("midrst_cut_count", 32'(cut_count), 32'd0);
    chk("midrst_address", 32'(address), 32'd0);
    chk("midrst_iready", 32'(iready), 32'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (ovalid) stale++;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    chk("midrst_cut_hold", 32'(cut_count), 32'd0);

    // Saturation of the cut counter.
    @(negedge clock);
    ivalid = 1'b1;
    r2 = 32'h7F800000;
    repeat (65534) @(negedge clock);
    ivalid = 1'b0;
    repeat (6) @(negedge clock);
    chk("sat_fffe", 32'(cut_count), 32'h0000FFFE);
    ivalid = 1'b1;
    repeat (3) @(negedge clock);
    ivalid = 1'b0;
    repeat (6) @(negedge clock);
    chk("sat_ffff", 32'(cut_count), 32'h0000FFFF);
    chk("sat_beyond_last", 32'(beyond_cut), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
